udp_cmd_ctrl: RTL and testbench
===============================

# udp_cmd_ctrl

Multi-channel UDP command decoder that sits behind the UDP receive path and drives one `transfer_flag` per image/data channel. It collects each received packet byte-by-byte, validates it against a fixed 5-byte command frame on packet completion, and then starts, stops or arms a counted burst on one or all channels. Burst channels count `frame_done` pulses and self-stop after N frames. Single-byte packets `"1"`/`"0"` stay supported as a build option for the existing host tool.

## Interface
Parameters:
- `CH_NUM`, 4: number of channels, 1..8.
- `MAGIC`, 8'hA5: required first byte of a command frame.
- `CNT_W`, 16: burst frame-counter width; the argument field is 16 bits, zero-extended or truncated to `CNT_W`.

Ports:
- `clk`  in  1  system clock; the single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `udp_rec_en`  in  1  `udp_rec_data` is valid this cycle.
- `udp_rec_data`  in  8  received payload byte.
- `udp_rec_pkt_done`  in  1  single-cycle pulse marking the end of a packet.
- `udp_rec_byte_num`  in  16  payload length of the packet; valid while `udp_rec_pkt_done` is high.
- `frame_done`  in  CH_NUM  per-channel single-cycle pulse marking one frame sent.
- `transfer_flag`  out  CH_NUM  1 = channel transferring.
- `cmd_ok`  out  1  one-cycle pulse: the command was accepted and applied.
- `cmd_err`  out  1  one-cycle pulse: the packet was rejected and no state changed.

## Operation
- Command frame is 5 bytes: B0 = `MAGIC`, B1 = channel (0..CH_NUM-1, or 8'hFF = all), B2 = opcode, B3:B4 = argument, big-endian.
- Opcodes:
  - 8'h00: stop. Flag cleared, counter cleared.
  - 8'h01: start continuous. Flag set, counter cleared.
  - 8'h02: burst. Flag set, counter loaded with the argument.
- State machine:
  - COLLECT (reset state): each `udp_rec_en` byte is stored at index `idx` (B0..B4). `idx` saturates at 6, which marks the packet as oversize.
  - `udp_rec_pkt_done` moves COLLECT to EXEC. A byte with `udp_rec_en` in that same cycle is included in the packet. `idx` resets to 0.
  - EXEC (1 cycle): validate, apply, pulse `cmd_ok` or `cmd_err`, then return to COLLECT. A byte arriving during EXEC is B0 of the next packet.
- Rejection (pulse `cmd_err`, no state change) occurs on any of:
  - `udp_rec_byte_num` ≠ 5, or `idx` ≠ 5;
  - B0 ≠ `MAGIC`;
  - B1 ≥ CH_NUM and B1 ≠ 8'hFF;
  - opcode not in {0, 1, 2};
  - burst with argument 0.
- Burst count:
  - While a channel's flag is set and its counter is nonzero, each `frame_done` decrements the counter.
  - The decrement from 1 to 0 also clears the flag in the same edge.
  - In continuous mode (counter = 0), `frame_done` is ignored.
  - `frame_done` on a channel whose flag is clear is ignored.
- Simultaneous events: if EXEC targets a channel while that channel's `frame_done` is high in the same cycle, the command wins and that `frame_done` is discarded. Channels not targeted still count normally.
- A start or burst on a channel that is already running overwrites its mode and count.

## Timing
- Reset values: `transfer_flag` = 0, `cmd_ok` = 0, `cmd_err` = 0, all counters = 0, state COLLECT, `idx` = 0.
- `udp_rec_pkt_done` sampled at edge k leads to EXEC in cycle k+1. `transfer_flag`, `cmd_ok` and `cmd_err` update at edge k+1, so they are visible 2 cycles after `pkt_done` is asserted.
- A `frame_done` sampled at edge k changes the counter and flag at edge k, visible 1 cycle later.
- `cmd_ok` and `cmd_err` are mutually exclusive and last exactly 1 cycle.
- Reset asserted mid-packet discards the partial packet. Reset asserted mid-burst clears the flag and counter immediately (asynchronously).
- Back-to-back packets are supported with a minimum of one idle cycle (EXEC) between `pkt_done` pulses.

## Configuration
- `LEGACY_CMD_EN` defined:
  - A 1-byte packet 8'h31 (`"1"`) starts all channels continuous and pulses `cmd_ok`.
  - A 1-byte packet 8'h30 (`"0"`) stops all channels and pulses `cmd_ok`.
  - Any other 1-byte packet pulses `cmd_err`.
- `LEGACY_CMD_EN` undefined: every 1-byte packet is rejected with `cmd_err`. No legacy decode logic is synthesised.

## Test plan
- Reset, then send A5 02 01 00 00 (CH_NUM=4) → `transfer_flag` = 4'b0100 two cycles after `pkt_done`, one `cmd_ok` pulse.
- Send A5 FF 02 00 03, then 3 `frame_done` pulses on ch0 → ch0 flag clears on the third pulse. Other channels stay set until they also receive 3 pulses.
- Send malformed packets A5 04 01 00 00, A4 00 01 00 00, a 6-byte packet, and A5 00 02 00 00 → `cmd_err` each time, flags unchanged.
- Run a burst of 2 on ch1 with `frame_done[1]` coinciding with an EXEC of stop-ch1 → flag 0, counter 0, no underflow.
- Assert `rst` during byte B2 of a packet, then send a clean start-ch3 packet → ch3 flag 1 and no stale bytes used.
- With `LEGACY_CMD_EN`, send "1" then "0" → flags 4'hF then 4'h0. Without it, the same packets give two `cmd_err` pulses and flags stay 0.

Source files
------------

// File: rtl/udp_cmd_ctrl.sv
// UDP command decoder: collects a 5-byte command frame and starts, stops or arms counted bursts per channel.
// Build option LEGACY_CMD_EN adds single-byte "1"/"0" start-all/stop-all packets.
module udp_cmd_ctrl #(
  parameter int          CH_NUM = 4,
  parameter logic [7:0]  MAGIC  = 8'hA5,
  parameter int          CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              udp_rec_en,
  input  logic [7:0]        udp_rec_data,
  input  logic              udp_rec_pkt_done,
  input  logic [15:0]       udp_rec_byte_num,
  input  logic [CH_NUM-1:0] frame_done,
  output logic [CH_NUM-1:0] transfer_flag,
  output logic              cmd_ok,
  output logic              cmd_err
);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_EXEC    = 1'b1;

  logic [0:0]       state;
  logic [2:0]       idx;
  logic [2:0]       idx_inc;
  logic [2:0]       pkt_len;
  logic             len5;
`ifdef LEGACY_CMD_EN
  logic             len1;
`endif
  logic [7:0]       pkt_b [5];
  logic [CNT_W-1:0] cnt [CH_NUM];

  logic [15:0]       arg;
  logic [CNT_W-1:0]  arg_c;
  logic              all_ch;
  logic              frame_ok;
  logic              cmd_valid;
  logic              set_flag;
  logic              load;
  logic [CH_NUM-1:0] tgt;
  logic [CH_NUM-1:0] exec_hit;

  // idx stops at 6 so any oversize packet stays distinguishable from a 5-byte one
  assign idx_inc = (idx == 3'd6) ? 3'd6 : idx + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_COLLECT;
      idx     <= 3'd0;
      pkt_len <= 3'd0;
      len5    <= 1'b0;
`ifdef LEGACY_CMD_EN
      len1    <= 1'b0;
`endif
      for (int i = 0; i < 5; i++) pkt_b[i] <= 8'h00;
    end else begin
      if (udp_rec_en && idx < 3'd5) pkt_b[idx] <= udp_rec_data;
      if (state == ST_COLLECT && udp_rec_pkt_done) begin
        state   <= ST_EXEC;
        idx     <= 3'd0;
        pkt_len <= udp_rec_en ? idx_inc : idx;
        len5    <= (udp_rec_byte_num == 16'd5);
`ifdef LEGACY_CMD_EN
        len1    <= (udp_rec_byte_num == 16'd1);
`endif
      end else begin
        state <= ST_COLLECT;
        if (udp_rec_en) idx <= idx_inc;
      end
    end
  end

  assign arg    = {pkt_b[3], pkt_b[4]};
  assign all_ch = (pkt_b[1] == 8'hFF);

  always_comb begin
    arg_c = '0;
    for (int i = 0; i < CNT_W && i < 16; i++) arg_c[i] = arg[i];
  end

  assign frame_ok = len5 && (pkt_len == 3'd5) && (pkt_b[0] == MAGIC)
                 && (all_ch || pkt_b[1] < 8'(CH_NUM))
                 && (pkt_b[2] <= 8'h02)
                 && !(pkt_b[2] == 8'h02 && arg_c == '0);

  always_comb begin
    cmd_valid = frame_ok;
    set_flag  = (pkt_b[2] != 8'h00);
    load      = (pkt_b[2] == 8'h02);
    tgt       = '0;
    for (int i = 0; i < CH_NUM; i++) tgt[i] = all_ch || (pkt_b[1] == 8'(i));
`ifdef LEGACY_CMD_EN
    if (len1 && pkt_len == 3'd1 && (pkt_b[0] == 8'h31 || pkt_b[0] == 8'h30)) begin
      cmd_valid = 1'b1;
      set_flag  = (pkt_b[0] == 8'h31);
      load      = 1'b0;
      tgt       = '1;
    end
`endif
  end

  assign exec_hit = (state == ST_EXEC && cmd_valid) ? tgt : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ok  <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      cmd_ok  <= (state == ST_EXEC) && cmd_valid;
      cmd_err <= (state == ST_EXEC) && !cmd_valid;
    end
  end

  // A command on a channel overrides a coincident frame_done on that channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      transfer_flag <= '0;
      for (int i = 0; i < CH_NUM; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (exec_hit[i]) begin
          transfer_flag[i] <= set_flag;
          cnt[i]           <= load ? arg_c : '0;
        end else if (frame_done[i] && transfer_flag[i] && cnt[i] != '0) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
          if (cnt[i] == CNT_W'(1)) transfer_flag[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_udp_cmd_ctrl.sv
// Self-checking bench for udp_cmd_ctrl: directed plan steps plus random packets/frames against a channel model.
module tb_udp_cmd_ctrl;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          udp_rec_en;
  logic [7:0]    udp_rec_data;
  logic          udp_rec_pkt_done;
  logic [15:0]   udp_rec_byte_num;
  logic [CH-1:0] frame_done;
  logic [CH-1:0] transfer_flag;
  logic          cmd_ok;
  logic          cmd_err;

  int n_assert = 0;
  int n_fail   = 0;

  bit m_flag [CH];
  int m_cnt  [CH];

  byte unsigned pk [$];

  udp_cmd_ctrl #(.CH_NUM(CH), .MAGIC(8'hA5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .udp_rec_en(udp_rec_en), .udp_rec_data(udp_rec_data),
    .udp_rec_pkt_done(udp_rec_pkt_done), .udp_rec_byte_num(udp_rec_byte_num),
    .frame_done(frame_done), .transfer_flag(transfer_flag), .cmd_ok(cmd_ok), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  function automatic logic [CH-1:0] exp_flags();
    logic [CH-1:0] f;
    for (int i = 0; i < CH; i++) f[i] = m_flag[i];
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin m_flag[i] = 0; m_cnt[i] = 0; end
  endtask

  task automatic model_fd(input logic [CH-1:0] fd, input logic [CH-1:0] skip);
    for (int i = 0; i < CH; i++)
      if (fd[i] && !skip[i] && m_flag[i] && m_cnt[i] > 0) begin
        m_cnt[i]--;
        if (m_cnt[i] == 0) m_flag[i] = 0;
      end
  endtask

  // Called at posedge+1; drives pk byte-per-cycle with pkt_done on the last byte
  task automatic send(input int bn, input bit rnd_fd, input logic [CH-1:0] fd_exec);
    logic [CH-1:0] fd;
    logic [CH-1:0] tgt;
    bit ok;
    int op, arg;
    for (int j = 0; j < pk.size(); j++) begin
      udp_rec_en   = 1'b1;
      udp_rec_data = pk[j];
      if (j == pk.size() - 1) begin
        udp_rec_pkt_done = 1'b1;
        udp_rec_byte_num = 16'(bn);
      end
      fd = rnd_fd ? CH'($urandom) : '0;
      frame_done = fd;
      @(posedge clk);
      model_fd(fd, '0);
      #1;
    end
    udp_rec_en = 1'b0; udp_rec_pkt_done = 1'b0; udp_rec_byte_num = 16'd0;
    chk("flags_before_exec", 32'(transfer_flag), 32'(exp_flags()));
    chk("ok_before_exec", 32'(cmd_ok), 32'd0);
    ok = 0; tgt = '0; op = 0; arg = 0;
    if (bn == 5 && pk.size() == 5 && pk[0] == 8'hA5 && (pk[1] < CH || pk[1] == 8'hFF)
        && pk[2] <= 2 && !(pk[2] == 2 && pk[3] == 0 && pk[4] == 0)) begin
      ok = 1; op = pk[2]; arg = pk[3] * 256 + pk[4];
      if (pk[1] == 8'hFF) tgt = '1; else tgt[pk[1]] = 1'b1;
    end
`ifdef LEGACY_CMD_EN
    else if (bn == 1 && pk.size() == 1 && (pk[0] == 8'h31 || pk[0] == 8'h30)) begin
      ok = 1; tgt = '1; op = (pk[0] == 8'h31) ? 1 : 0; arg = 0;
    end
`endif
    frame_done = fd_exec;
    @(posedge clk);
    model_fd(fd_exec, tgt);
    for (int i = 0; i < CH; i++)
      if (tgt[i]) begin
        m_flag[i] = (op != 0);
        m_cnt[i]  = (op == 2) ? arg : 0;
      end
    #1;
    frame_done = '0;
    chk("cmd_ok", 32'(cmd_ok), 32'(ok));
    chk("cmd_err", 32'(cmd_err), 32'(!ok));
    chk("flags_after_exec", 32'(transfer_flag), 32'(exp_flags()));
    @(posedge clk); #1;
    chk("pulse_width", 32'({cmd_ok, cmd_err}), 32'd0);
  endtask

  task automatic send5(input byte unsigned b0, b1, b2, b3, b4, input logic [CH-1:0] fd_exec);
    pk = {b0, b1, b2, b3, b4};
    send(5, 0, fd_exec);
  endtask

  task automatic frames(input logic [CH-1:0] fd);
    frame_done = fd;
    @(posedge clk);
    model_fd(fd, '0);
    #1;
    frame_done = '0;
    chk("flags_frame", 32'(transfer_flag), 32'(exp_flags()));
  endtask

  initial begin
    rst = 1'b1; udp_rec_en = 0; udp_rec_data = 0; udp_rec_pkt_done = 0;
    udp_rec_byte_num = 0; frame_done = '0;
    model_reset();
    #12;
    chk("reset_flags", 32'(transfer_flag), 32'd0);
    chk("reset_ok", 32'(cmd_ok), 32'd0);
    chk("reset_err", 32'(cmd_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // start ch2 continuous
    send5(8'hA5, 8'h02, 8'h01, 8'h00, 8'h00, '0);
    chk("start_ch2", 32'(transfer_flag), 32'h4);
    frames(4'b0100);
    chk("continuous_ignores_fd", 32'(transfer_flag), 32'h4);

    // burst 3 on all channels
    send5(8'hA5, 8'hFF, 8'h02, 8'h00, 8'h03, '0);
    frames(4'b0001); frames(4'b0001); frames(4'b0001);
    chk("ch0_burst_done", 32'(transfer_flag), 32'hE);
    frames(4'b1110); frames(4'b1110);
    chk("others_still_set", 32'(transfer_flag), 32'hE);
    frames(4'b1110);
    chk("all_burst_done", 32'(transfer_flag), 32'h0);
    frames(4'b1111);

    // malformed packets, with ch1 running so "unchanged" is non-trivial
    send5(8'hA5, 8'h01, 8'h01, 8'h00, 8'h00, '0);
    send5(8'hA5, 8'h04, 8'h01, 8'h00, 8'h00, '0);
    send5(8'hA4, 8'h00, 8'h01, 8'h00, 8'h00, '0);
    send5(8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, '0);
    send5(8'hA5, 8'h00, 8'h03, 8'h00, 8'h00, '0);
    pk = {8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    send(6, 0, '0);
    pk = {8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(5, 0, '0);
    pk = {8'hA5, 8'h00, 8'h01, 8'h00};
    send(5, 0, '0);
    chk("flags_after_rejects", 32'(transfer_flag), 32'h2);

    // burst 2 on ch1, stop coinciding with frame_done[1]
    send5(8'hA5, 8'h01, 8'h02, 8'h00, 8'h02, '0);
    frames(4'b0010);
    send5(8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 4'b0010);
    chk("stop_wins", 32'(transfer_flag), 32'h0);
    frames(4'b0010);
    // re-burst over a coincident frame_done: count must reload to 3
    send5(8'hA5, 8'h01, 8'h02, 8'h00, 8'h02, '0);
    frames(4'b0010);
    send5(8'hA5, 8'h01, 8'h02, 8'h00, 8'h03, 4'b0011);
    frames(4'b0010); frames(4'b0010);
    chk("reload_count", 32'(transfer_flag), 32'h2);
    frames(4'b0010);
    chk("reload_done", 32'(transfer_flag), 32'h0);

    // reset mid-packet while channels run
    send5(8'hA5, 8'hFF, 8'h02, 8'h00, 8'h05, '0);
    udp_rec_en = 1'b1; udp_rec_data = 8'hA5;
    @(posedge clk); #1;
    udp_rec_data = 8'h03;
    @(posedge clk); #1;
    udp_rec_data = 8'h01;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_reset_flags", 32'(transfer_flag), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; udp_rec_en = 1'b0;
    pk = {8'h01, 8'h00, 8'h00};
    send(5, 0, '0);
    send5(8'hA5, 8'h03, 8'h01, 8'h00, 8'h00, '0);
    chk("start_ch3_after_reset", 32'(transfer_flag), 32'h8);

    // single-byte packets
    send5(8'hA5, 8'hFF, 8'h00, 8'h00, 8'h00, '0);
    pk = {8'h31}; send(1, 0, '0);
`ifdef LEGACY_CMD_EN
    chk("legacy_1", 32'(transfer_flag), 32'hF);
`else
    chk("legacy_1", 32'(transfer_flag), 32'h0);
`endif
    pk = {8'h30}; send(1, 0, '0);
    chk("legacy_0", 32'(transfer_flag), 32'h0);
    pk = {8'h32}; send(1, 0, '0);

    // random packets and frame pulses
    for (int it = 0; it < 60; it++) begin
      int r;
      r = $urandom_range(0, 3);
      if (r == 0) begin
        frames(CH'($urandom));
      end else begin
        byte unsigned c, o, a0, a1;
        int bn, ln;
        c  = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom_range(0, 4));
        o  = ($urandom_range(0, 7) == 0) ? 8'h03 : 8'($urandom_range(0, 2));
        a0 = ($urandom_range(0, 5) == 0) ? 8'h01 : 8'h00;
        a1 = 8'($urandom_range(0, 3));
        pk = {($urandom_range(0, 9) == 0) ? 8'hA4 : 8'hA5, c, o, a0, a1};
        ln = $urandom_range(0, 9);
        if (ln == 0) pk.push_back(8'h00);
        else if (ln == 1) void'(pk.pop_back());
        bn = ($urandom_range(0, 9) == 0) ? pk.size() : 5;
        send(bn, 1, CH'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
